// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. long-latency results, with busy scoreboard.
// Optional REGFILE_INIT_SWEEP_EN: zero x1..x31 after reset before normal operation.
module regfile_wb_arbiter #(
    parameter int unsigned LU_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_pipe_we,
    input  logic [4:0]            i_pipe_rd,
    input  logic [DATA_WIDTH-1:0] i_pipe_data,
    input  logic                  i_lu_valid,
    output logic                  o_lu_ready,
    input  logic [4:0]            i_lu_rd,
    input  logic [DATA_WIDTH-1:0] i_lu_data,
    input  logic                  i_lu_issue,
    input  logic [4:0]            i_lu_issue_rd,
    output logic [31:0]           o_busy,
    output logic                  o_rf_we,
    output logic [4:0]            o_rf_waddr,
    output logic [DATA_WIDTH-1:0] o_rf_wdata,
    output logic                  o_stall_req,
    output logic                  o_init_done
);

    localparam int unsigned PTR_W    = (LU_FIFO_DEPTH > 1) ? $clog2(LU_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(LU_FIFO_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] data;
    } lu_entry_t;

    lu_entry_t               fifo_mem [LU_FIFO_DEPTH];
    lu_entry_t               head;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    pipe_win;
    logic                    issue_set;
    logic [31:0]             busy_next;
    logic [STARVE_W-1:0]     starve_cnt;
    logic [STARVE_W-1:0]     starve_next;
    logic                    stall_q;
    logic                    sweeping;
    logic                    sweep_we;
    logic [4:0]              sweep_addr;

`ifdef REGFILE_INIT_SWEEP_EN
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} sweep_state_t;

    sweep_state_t state;
    sweep_state_t state_next;
    logic [4:0]   addr_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            sweep_addr <= 5'd1;
        end else begin
            state      <= state_next;
            sweep_addr <= addr_next;
        end
    end

    // Walk x1..x31 once, one zero write per cycle.
    always_comb begin
        state_next = state;
        addr_next  = sweep_addr;
        sweep_we   = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_SWEEP;
                addr_next  = 5'd1;
            end
            S_SWEEP: begin
                sweep_we = 1'b1;
                if (sweep_addr == 5'd31) state_next = S_DONE;
                else                     addr_next  = sweep_addr + 5'd1;
            end
            default: ;
        endcase
    end

    assign sweeping    = (state != S_DONE);
    assign o_init_done = (state == S_DONE);
`else
    assign sweeping    = 1'b0;
    assign sweep_we    = 1'b0;
    assign sweep_addr  = 5'd0;
    assign o_init_done = 1'b1;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(LU_FIFO_DEPTH));
    assign o_lu_ready = !fifo_full && !sweeping;
    assign push       = i_lu_valid && o_lu_ready;
    assign head       = fifo_mem[rd_ptr];
    assign pipe_win   = i_pipe_we && !i_stall && (i_pipe_rd != 5'd0) && !sweeping;
    assign issue_set  = i_lu_issue && (i_lu_issue_rd != 5'd0) && !sweeping;

    // Port mux: sweep, then pipeline, then FIFO head; rd=0 heads are dropped.
    always_comb begin
        o_rf_we    = 1'b0;
        o_rf_waddr = 5'd0;
        o_rf_wdata = '0;
        pop        = 1'b0;
        if (sweep_we) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = sweep_addr;
        end else if (pipe_win) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = i_pipe_rd;
            o_rf_wdata = i_pipe_data;
        end else if (!fifo_empty && !sweeping) begin
            pop        = 1'b1;
            o_rf_we    = (head.rd != 5'd0);
            o_rf_waddr = head.rd;
            o_rf_wdata = head.data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= '{rd: i_lu_rd, data: i_lu_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Issue set takes priority over a same-cycle pop clear.
    always_comb begin
        busy_next = o_busy;
        if (pop)       busy_next[head.rd]       = 1'b0;
        if (issue_set) busy_next[i_lu_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || pop)                          starve_next = '0;
        else if (starve_cnt < STARVE_W'(STARVE_LIMIT))  starve_next = starve_cnt + STARVE_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy     <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            o_busy     <= busy_next;
            starve_cnt <= starve_next;
            stall_q    <= (starve_next == STARVE_W'(STARVE_LIMIT));
        end
    end

    assign o_stall_req = stall_q || sweeping;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_pipe_we;
    logic [4:0]  i_pipe_rd;
    logic [31:0] i_pipe_data;
    logic        i_lu_valid;
    logic        o_lu_ready;
    logic [4:0]  i_lu_rd;
    logic [31:0] i_lu_data;
    logic        i_lu_issue;
    logic [4:0]  i_lu_issue_rd;
    logic [31:0] o_busy;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_stall_req;
    logic        o_init_done;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
        .i_pipe_we(i_pipe_we), .i_pipe_rd(i_pipe_rd), .i_pipe_data(i_pipe_data),
        .i_lu_valid(i_lu_valid), .o_lu_ready(o_lu_ready), .i_lu_rd(i_lu_rd),
        .i_lu_data(i_lu_data), .i_lu_issue(i_lu_issue), .i_lu_issue_rd(i_lu_issue_rd),
        .o_busy(o_busy), .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr),
        .o_rf_wdata(o_rf_wdata), .o_stall_req(o_stall_req), .o_init_done(o_init_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_stall = 1'b0; i_pipe_we = 1'b0; i_pipe_rd = 5'd0; i_pipe_data = 32'd0;
        i_lu_valid = 1'b0; i_lu_rd = 5'd0; i_lu_data = 32'd0;
        i_lu_issue = 1'b0; i_lu_issue_rd = 5'd0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"},   64'(o_rf_we),    64'd1);
        check({tag, "_addr"}, 64'(o_rf_waddr), 64'(a));
        check({tag, "_data"}, 64'(o_rf_wdata), 64'(d));
    endtask

`ifdef REGFILE_INIT_SWEEP_EN
    task automatic wait_first_write();
        int n = 0;
        while (!o_rf_we && n < 4) begin
            step();
            n++;
        end
        check("sweep_start", 64'(o_rf_we), 64'd1);
    endtask
`endif

    initial begin
        idle();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_busy",  64'(o_busy),  64'd0);
        check("rst_we",    64'(o_rf_we), 64'd0);
`ifdef REGFILE_INIT_SWEEP_EN
        check("rst_init",  64'(o_init_done), 64'd0);
        i_rst_n = 1'b1;
        wait_first_write();
        for (int k = 1; k < 12; k++) begin
            check_write("sweep_a", 5'(k), 32'd0);
            step();
        end
        check("sweep_at12", 64'(o_rf_waddr), 64'd12);
        i_rst_n = 1'b0;
        #1;
        check("sweep_rst_we", 64'(o_rf_we), 64'd0);
        step();
        i_rst_n = 1'b1;
        wait_first_write();
        for (int k = 1; k <= 31; k++) begin
            check_write("sweep_b", 5'(k), 32'd0);
            check("sweep_init", 64'(o_init_done), 64'd0);
            step();
        end
        check("sweep_done", 64'(o_init_done), 64'd1);
        check("sweep_stall", 64'(o_stall_req), 64'd0);
`else
        check("rst_stall", 64'(o_stall_req), 64'd0);
        check("rst_ready", 64'(o_lu_ready),  64'd1);
        check("rst_init",  64'(o_init_done), 64'd1);
        i_rst_n = 1'b1;
        step();
`endif
        // Pipeline writeback, then rd=0 suppression
        i_pipe_we = 1'b1; i_pipe_rd = 5'd5; i_pipe_data = 32'hDEADBEEF;
        #1;
        check_write("pipe", 5'd5, 32'hDEADBEEF);
        i_pipe_rd = 5'd0;
        #1;
        check("pipe_x0_we", 64'(o_rf_we), 64'd0);
        step();
        idle();

        // Long-latency path with scoreboard
        i_lu_issue = 1'b1; i_lu_issue_rd = 5'd7;
        step();
        i_lu_issue = 1'b0;
        check("lu_busy_set", 64'(o_busy), 64'h80);
        i_lu_valid = 1'b1; i_lu_rd = 5'd7; i_lu_data = 32'h1234;
        #1;
        check("lu_ready", 64'(o_lu_ready), 64'd1);
        check("lu_not_yet", 64'(o_rf_we), 64'd0);
        step();
        i_lu_valid = 1'b0;
        #1;
        check_write("lu", 5'd7, 32'h1234);
        check("lu_busy_hold", 64'(o_busy), 64'h80);
        step();
        check("lu_busy_clr", 64'(o_busy), 64'd0);
        check("lu_empty_we", 64'(o_rf_we), 64'd0);

        // Starvation: pipeline owns the port until i_stall
        i_pipe_we = 1'b1; i_pipe_rd = 5'd3; i_pipe_data = 32'd1;
        i_lu_valid = 1'b1; i_lu_rd = 5'd10; i_lu_data = 32'hAA;
        step();
        i_lu_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("starve_low", 64'(o_stall_req), 64'd0);
        end
        step();
        check("starve_req", 64'(o_stall_req), 64'd1);
        i_stall = 1'b1;
        #1;
        check_write("starve_pop", 5'd10, 32'hAA);
        step();
        check("starve_drop", 64'(o_stall_req), 64'd0);
        check("starve_empty", 64'(o_rf_we), 64'd0);
        idle();

        // Backpressure: three results into a two-deep FIFO
        i_pipe_we = 1'b1; i_pipe_rd = 5'd3; i_pipe_data = 32'd2;
        i_lu_valid = 1'b1; i_lu_rd = 5'd11; i_lu_data = 32'h111;
        step();
        i_lu_rd = 5'd12; i_lu_data = 32'h222;
        check("bp_ready1", 64'(o_lu_ready), 64'd1);
        step();
        i_lu_rd = 5'd13; i_lu_data = 32'h333;
        check("bp_full", 64'(o_lu_ready), 64'd0);
        step();
        check("bp_held", 64'(o_lu_ready), 64'd0);
        i_pipe_we = 1'b0;
        #1;
        check_write("bp_w0", 5'd11, 32'h111);
        step();
        check_write("bp_w1", 5'd12, 32'h222);
        step();
        i_lu_valid = 1'b0;
        check_write("bp_w2", 5'd13, 32'h333);
        step();
        check("bp_done", 64'(o_rf_we), 64'd0);
        idle();

        // Same-cycle set/clear, then a discarded rd=0 head
        i_lu_issue = 1'b1; i_lu_issue_rd = 5'd9;
        step();
        i_lu_issue = 1'b0;
        i_lu_valid = 1'b1; i_lu_rd = 5'd9; i_lu_data = 32'h99;
        step();
        i_lu_valid = 1'b0;
        i_lu_issue = 1'b1; i_lu_issue_rd = 5'd9;
        #1;
        check_write("sb_pop", 5'd9, 32'h99);
        step();
        i_lu_issue_rd = 5'd0;
        check("sb_set_wins", 64'(o_busy), 64'h200);
        i_lu_valid = 1'b1; i_lu_rd = 5'd0; i_lu_data = 32'h55;
        step();
        i_lu_valid = 1'b0; i_lu_issue = 1'b0;
        #1;
        check("x0_pop_we", 64'(o_rf_we), 64'd0);
        step();
        check("x0_busy", 64'(o_busy), 64'h200);
        check("x0_drained", 64'(o_rf_we), 64'd0);

        // Reset mid-operation drops FIFO and scoreboard
        i_pipe_we = 1'b1; i_pipe_rd = 5'd3;
        i_lu_issue = 1'b1; i_lu_issue_rd = 5'd20;
        i_lu_valid = 1'b1; i_lu_rd = 5'd21; i_lu_data = 32'h77;
        step();
        idle();
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  64'(o_busy),     64'd0);
`ifndef REGFILE_INIT_SWEEP_EN
        check("mid_rst_ready", 64'(o_lu_ready), 64'd1);
        step();
        i_rst_n = 1'b1;
        step();
        check("mid_rst_fifo", 64'(o_rf_we), 64'd0);
`else
        step();
        i_rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port; feeds the write enable, address and data into both source-register RAM copies.
- Arbitrates between the in-order pipeline writeback (MA→WB) and a long-latency unit (divider/FPU) that returns results out of band through a valid/ready handshake with a small FIFO.
- Keeps a per-register busy scoreboard for long-latency destinations, used by hazard logic.
- Raises a stall request when long-latency results are starved of the port.

Parameters:
- LU_FIFO_DEPTH, 2: long-latency result FIFO entries, power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO may go without a dequeue before o_stall_req asserts.
- DATA_WIDTH, 32: register width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_stall  in  1  pipeline stall (pipeline_ctrl.stall)
- i_pipe_we  in  1  pipeline writeback enable
- i_pipe_rd  in  5  pipeline destination register
- i_pipe_data  in  DATA_WIDTH  pipeline writeback data
- i_lu_valid  in  1  long-latency result valid
- o_lu_ready  out  1  FIFO can accept a result
- i_lu_rd  in  5  long-latency destination register
- i_lu_data  in  DATA_WIDTH  long-latency result
- i_lu_issue  in  1  long-latency op issued this cycle
- i_lu_issue_rd  in  5  its destination register
- o_busy  out  32  scoreboard; bit n set means xn has a pending long-latency write
- o_rf_we  out  1  regfile write enable
- o_rf_waddr  out  5  regfile write address
- o_rf_wdata  out  DATA_WIDTH  regfile write data
- o_stall_req  out  1  request a pipeline stall
- o_init_done  out  1  regfile initialised

Behaviour:
- Reset values: FIFO empty; o_busy=0; starve counter=0; o_stall_req=0; o_lu_ready=1; o_rf_we=0. Without the optional feature, o_init_done=1.
- FIFO
  - Push on i_lu_valid & o_lu_ready; o_lu_ready = !full.
  - Registered storage: an accepted entry is first eligible for the port on the next cycle.
  - Push and pop in the same cycle when full are legal; occupancy is unchanged.
  - Pointers wrap modulo LU_FIFO_DEPTH.
- Port arbitration (combinational outputs, zero latency)
  - pipe_win = i_pipe_we & !i_stall & (i_pipe_rd≠0).
  - If pipe_win: o_rf_we=1, address and data from the pipeline inputs; the FIFO does not pop.
  - Else if FIFO non-empty: pop the head. o_rf_we = (head.rd≠0), address and data from the head.
  - A head with rd=0 is popped and discarded: no write, no scoreboard effect.
  - Else: o_rf_we=0; address and data are don't-care, driven 0.
- Scoreboard
  - Set bit i_lu_issue_rd on i_lu_issue when rd≠0.
  - Clear bit head.rd when that head is popped.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is always 0.
  - A pipeline write to a busy register does not touch the scoreboard.
- Starvation
  - Counter increments each cycle the FIFO is non-empty and no pop occurs; it saturates at STARVE_LIMIT.
  - Counter clears on any pop or when the FIFO is empty.
  - o_stall_req is registered and set when the counter reaches STARVE_LIMIT.
  - While o_stall_req is set, the pipeline stalls, so the FIFO head wins the port the next cycle and o_stall_req deasserts the cycle after the pop.
- Reset mid-operation: all state clears asynchronously; FIFO contents are lost and the scoreboard is cleared.

Optional Feature:
- REGFILE_INIT_SWEEP_EN, defined:
  - After reset release, a sweep FSM walks IDLE→SWEEP→DONE.
  - SWEEP writes 0 to x1..x31, one per cycle (o_rf_we=1, o_rf_waddr=counter, o_rf_wdata=0), 31 cycles.
  - During SWEEP: o_init_done=0, o_stall_req=1, o_lu_ready=0; pipeline writes and i_lu_issue are ignored.
  - DONE sets o_init_done=1, then normal operation.
  - Reset asserted during SWEEP restarts the sweep from x1.
- REGFILE_INIT_SWEEP_EN undefined: no FSM; o_init_done is tied to 1; the RAM powers up with its initial contents.

Test Plan:
- Pipeline only: i_pipe_we=1, rd=5, data=0xDEADBEEF, i_stall=0 → same cycle o_rf_we=1, waddr=5, wdata=0xDEADBEEF. Repeat with rd=0 → o_rf_we=0.
- LU path: issue rd=7 (o_busy[7]=1), then push rd=7, data=0x1234 with pipeline idle → next cycle o_rf_we=1, waddr=7, wdata=0x1234, and o_busy[7]=0 the following cycle.
- Starvation: push one LU result while pipe_win is held every cycle → o_stall_req=1 after STARVE_LIMIT=4 cycles. Drive i_stall=1 → LU write occurs, o_stall_req drops the next cycle.
- Backpressure: hold pipe_win and push 3 results with depth 2 → o_lu_ready=0 after 2 pushes; the third is held until a pop, and all 3 are written in order.
- Same-cycle scoreboard: pop head rd=9 while issuing rd=9 → o_busy[9] stays 1. Pop of head rd=0 → no write, o_busy unchanged.
- REGFILE_INIT_SWEEP_EN: release reset → 31 writes of 0 to addresses 1..31, then o_init_done=1. Assert reset at sweep address 12 → the sweep restarts at 1.
